lock_sequencer: RTL

Central control FSM for the three-digit lock. It edge-detects the set/lock/unlock buttons and validates and stores the 12-bit BCD passcode. It compares unlock attempts against the stored code, counts failed trials and enforces the lockout. Its registered outputs drive the passcode, status and trials seven-segment drivers directly, replacing the ad-hoc glue between the storage, comparator and trials logic.

---
 rtl/lock_sequencer_if.sv | 21 ++
 rtl/lock_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/lock_sequencer_if.sv
// Button, passcode and display signals of the lock sequencer.
interface lock_sequencer_if;
    logic        set;
    logic        lock;
    logic        unlock;
    logic [11:0] code_in;
    logic [11:0] stored_code;
    logic        status_open;
    logic        blocked;
    logic [1:0]  trials;
    logic        bad_code;

    modport master (
        output set, lock, unlock, code_in,
        input  stored_code, status_open, blocked, trials, bad_code
    );
    modport slave (
        input  set, lock, unlock, code_in,
        output stored_code, status_open, blocked, trials, bad_code
    );
endinterface

// File: rtl/lock_sequencer.sv
// Control FSM of the three-digit BCD lock: button edge detect, code store/compare, trial count.
// Optional timed lockout exit when LOCKOUT_TIMER_EN is defined; otherwise BLOCKED holds until reset.
module lock_sequencer #(
    parameter int MAX_TRIALS     = 3,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    lock_sequencer_if.slave  bus
);
    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] OPEN    = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;
    localparam logic [1:0] BLOCKED = 2'd3;
    localparam logic [1:0] TRIALS_MAX = 2'(MAX_TRIALS);

    if (MAX_TRIALS < 1 || MAX_TRIALS > 3 || LOCKOUT_CYCLES < 1) begin : g_param_check
        $error("lock_sequencer: MAX_TRIALS must be 1..3 and LOCKOUT_CYCLES >= 1");
    end

    logic [1:0]  state, state_n;
    logic [11:0] code_n;
    logic [1:0]  trials_n;
    logic        bad_n;
    logic        set_q, lock_q, unlock_q;
    logic        set_ev, lock_ev, unlock_ev;
    logic        code_ok;

    assign set_ev    = bus.set    & ~set_q;
    assign lock_ev   = bus.lock   & ~lock_q;
    assign unlock_ev = bus.unlock & ~unlock_q;

    assign code_ok = (bus.code_in[3:0]  <= 4'd9) &&
                     (bus.code_in[7:4]  <= 4'd9) &&
                     (bus.code_in[11:8] <= 4'd9);

`ifdef LOCKOUT_TIMER_EN
    localparam int CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    logic [CW-1:0] cnt, cnt_n;
`endif

    always_comb begin
        state_n  = state;
        code_n   = bus.stored_code;
        trials_n = bus.trials;
        bad_n    = 1'b0;
`ifdef LOCKOUT_TIMER_EN
        cnt_n    = cnt;
`endif
        case (state)
            EMPTY, OPEN: begin
                if (set_ev) begin
                    if (code_ok) begin
                        code_n  = bus.code_in;
                        state_n = OPEN;
                    end else begin
                        bad_n = 1'b1;
                    end
                end else if (lock_ev && state == OPEN) begin
                    state_n  = LOCKED;
                    trials_n = 2'd0;
                end
            end
            LOCKED: begin
                // A set or lock on the same edge swallows the unlock even though both are ignored here.
                if (unlock_ev && !set_ev && !lock_ev) begin
                    if (bus.code_in == bus.stored_code) begin
                        state_n  = OPEN;
                        trials_n = 2'd0;
                    end else begin
                        trials_n = bus.trials + 2'd1;
                        if (trials_n == TRIALS_MAX) begin
                            state_n = BLOCKED;
`ifdef LOCKOUT_TIMER_EN
                            cnt_n   = CW'(LOCKOUT_CYCLES - 1);
`endif
                        end
                    end
                end
            end
            default: begin
`ifdef LOCKOUT_TIMER_EN
                if (cnt == '0) begin
                    state_n  = LOCKED;
                    trials_n = 2'd0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= EMPTY;
            set_q           <= 1'b0;
            lock_q          <= 1'b0;
            unlock_q        <= 1'b0;
            bus.stored_code <= 12'h000;
            bus.trials      <= 2'd0;
            bus.status_open <= 1'b1;
            bus.blocked     <= 1'b0;
            bus.bad_code    <= 1'b0;
        end else begin
            state           <= state_n;
            set_q           <= bus.set;
            lock_q          <= bus.lock;
            unlock_q        <= bus.unlock;
            bus.stored_code <= code_n;
            bus.trials      <= trials_n;
            bus.status_open <= (state_n == EMPTY) || (state_n == OPEN);
            bus.blocked     <= (state_n == BLOCKED);
            bus.bad_code    <= bad_n;
        end
    end

`ifdef LOCKOUT_TIMER_EN
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt_n;
    end
`endif
endmodule
